// File: rtl/serial_subtractor_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERIAL_SUB_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle; o_overflow exists only with SERIAL_SUB_OVF_EN.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             o_overflow;
`endif

    modport slave (
        input  i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_diff, o_borrow
`ifdef SERIAL_SUB_OVF_EN
        , output o_overflow
`endif
    );

    modport master (
        output i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_diff, o_borrow
`ifdef SERIAL_SUB_OVF_EN
        , input o_overflow
`endif
    );

endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// One-bit combinational half subtractor: diff = i_bit1 - i_bit2.
module half_subtractor (
    input  logic i_bit1,
    input  logic i_bit2,
    output logic diff,
    output logic borrow
);

    assign diff   = i_bit1 ^ i_bit2;
    assign borrow = ~i_bit1 & i_bit2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock; SERIAL_SUB_OVF_EN adds o_overflow.
// Result valid WIDTH cycles after accept; held in DONE until i_ready, no new accept until then.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > SERIAL_SUB_MAX_WIDTH) begin : g_bad_width
        $error("serial_subtractor: WIDTH out of range");
    end

    state_t           state_q;
    logic             ready_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             hs_diff;
    logic             hs_borrow0;
    logic             hs_borrow1;
    logic             bit_d;
    logic             borrow_d;

    // Full-subtract step: (a - b) first, then subtract the incoming borrow.
    half_subtractor u_hs_ab (
        .i_bit1 (a_q[0]),
        .i_bit2 (b_q[0]),
        .diff   (hs_diff),
        .borrow (hs_borrow0)
    );

    half_subtractor u_hs_bin (
        .i_bit1 (hs_diff),
        .i_bit2 (borrow_q),
        .diff   (bit_d),
        .borrow (hs_borrow1)
    );

    assign borrow_d = hs_borrow0 | hs_borrow1;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // On the last bit the shift registers hold the original operand MSBs in bit 0.
    assign ovf_d = (a_q[0] ^ b_q[0]) & (bit_d ^ a_q[0]);
    assign bus.o_overflow = ovf_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        a_q      <= bus.i_a;
                        b_q      <= bus.i_b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    diff_q   <= {bit_d, diff_q[WIDTH-1:1]};
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= ovf_d;
`endif
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_diff   = diff_q;
    assign bus.o_borrow = borrow_q;

endmodule
